// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU and its wide-operation sequencer:
//   - ALU op-code encodings (4-bit sel field)
//   - is_arith(): true for ops whose carry/overflow are meaningful and chain
//   - Sequencer FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_NOT  = 4'b0010;
    localparam logic [3:0] SEL_NOR  = 4'b0011;
    localparam logic [3:0] SEL_XOR  = 4'b0100;
    localparam logic [3:0] SEL_NAND = 4'b0101;
    localparam logic [3:0] SEL_ADD  = 4'b0110;
    localparam logic [3:0] SEL_SUB  = 4'b0111;

    // Only ADD and SUB propagate a carry between words and report cout/ovf.
    // Every other code, including unlisted ones, is treated as a logic op.
    function automatic logic is_arith(input logic [3:0] sel);
        return (sel == SEL_ADD) || (sel == SEL_SUB);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_word_mux.sv
// ---------------------------------------------------------------------------
// alu_word_mux
//   Selects word idx of a WORDS*W-bit vector (word 0 = least significant).
//   Ports:
//     vec   in   WORDS*W  packed wide operand
//     idx   in   IDX_W    word index, values >= WORDS give 0
//     word  out  W        selected word
// ---------------------------------------------------------------------------
module alu_word_mux #(
    parameter int W     = 32,
    parameter int WORDS = 2,
    parameter int IDX_W = 1
) (
    input  logic [WORDS*W-1:0] vec,
    input  logic [IDX_W-1:0]   idx,
    output logic [W-1:0]       word
);

    always_comb begin
        // NOTE: default first so every path assigns 'word'; otherwise an
        // unmatched index would hold the old value and infer a latch.
        word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                word = vec[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/alu_wide_sequencer.sv
// ---------------------------------------------------------------------------
// alu_wide_sequencer
//   Breaks a WORDS*W-bit operation into W-bit ALU operations, LSW first,
//   one word per cycle. For ADD/SUB the ALU carry-out of word k feeds the
//   carry-in of word k+1; logic ops get carry-in 0 above word 0. The wide
//   result and flags are returned on a valid/ready response port.
//   The ALU itself is combinational and lives in the parent.
//
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     req_valid/req_ready          request handshake
//     req_a, req_b (WORDS*W)       operands
//     req_sel (4), req_cin         op code, carry-in for word 0
//     alu_a, alu_b (W), alu_sel,   driven to the ALU while executing,
//     alu_cin                      0 otherwise
//     alu_y (W), alu_cout, alu_neg,
//     alu_zero, alu_ovf            ALU result and flags, same cycle
//     rsp_valid/rsp_ready          response handshake
//     rsp_y (WORDS*W)              wide result
//     rsp_cout, rsp_neg, rsp_zero,
//     rsp_ovf                      wide flags
//     rsp_err                      overflow trap
//
//   Configuration macro:
//     ALU_SEQ_OVF_TRAP_EN  defined: rsp_err mirrors final ADD/SUB overflow.
//                          undefined: rsp_err tied 0.
//
//   Timing: accept in cycle T, EXEC in T+1..T+WORDS, rsp_valid from T+WORDS+1.
// ---------------------------------------------------------------------------
module alu_wide_sequencer
    import alu_pkg::*;
#(
    parameter int W     = 32,
    parameter int WORDS = 2
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WORDS*W-1:0] req_a,
    input  logic [WORDS*W-1:0] req_b,
    input  logic [3:0]         req_sel,
    input  logic               req_cin,

    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic [3:0]         alu_sel,
    output logic               alu_cin,
    input  logic [W-1:0]       alu_y,
    input  logic               alu_cout,
    input  logic               alu_neg,
    input  logic               alu_zero,
    input  logic               alu_ovf,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WORDS*W-1:0] rsp_y,
    output logic               rsp_cout,
    output logic               rsp_neg,
    output logic               rsp_zero,
    output logic               rsp_ovf,
    output logic               rsp_err
);

    localparam int K_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

    seq_state_t state, state_next;

    logic [K_W-1:0]     k;
    logic [WORDS*W-1:0] a_q, b_q, y_q;
    logic [3:0]         sel_q;
    logic               cin_q;
    logic               carry_q;
    logic               zero_acc;
    logic               cout_q, neg_q, zero_q, ovf_q;

    logic [W-1:0]       word_a, word_b;
    logic               last_word;

    assign last_word = (k == K_LAST);

    alu_word_mux #(.W(W), .WORDS(WORDS), .IDX_W(K_W)) u_mux_a (
        .vec  (a_q),
        .idx  (k),
        .word (word_a)
    );

    alu_word_mux #(.W(W), .WORDS(WORDS), .IDX_W(K_W)) u_mux_b (
        .vec  (b_q),
        .idx  (k),
        .word (word_b)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values,
            // independent of the order the always_ff blocks are evaluated.
            state <= state_next;
        end
    end

    // Next state and handshake / ALU drive
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_sel    = '0;
        alu_cin    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                alu_a   = word_a;
                alu_b   = word_b;
                alu_sel = sel_q;
                // Word 0 takes the request carry; higher words chain only
                // for arithmetic ops.
                alu_cin = (k == '0) ? cin_q : (is_arith(sel_q) & carry_q);
                if (last_word) state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latch, word counter, result assembly and flag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and result registers are reset too, so a reset
            // mid-operation leaves no stale data visible on rsp_y.
            k        <= '0;
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
            sel_q    <= '0;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            zero_acc <= 1'b0;
            cout_q   <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_q      <= req_a;
                        b_q      <= req_b;
                        sel_q    <= req_sel;
                        cin_q    <= req_cin;
                        k        <= '0;
                        zero_acc <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (k == K_W'(i)) y_q[i*W +: W] <= alu_y;
                    end
                    carry_q  <= alu_cout;
                    zero_acc <= zero_acc & alu_zero;
                    if (last_word) begin
                        cout_q <= is_arith(sel_q) & alu_cout;
                        ovf_q  <= is_arith(sel_q) & alu_ovf;
                        neg_q  <= alu_neg;
                        zero_q <= zero_acc & alu_zero;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_y    = y_q;
    assign rsp_cout = cout_q;
    assign rsp_neg  = neg_q;
    assign rsp_zero = zero_q;
    assign rsp_ovf  = ovf_q;

`ifdef ALU_SEQ_OVF_TRAP_EN
    // ovf_q is already masked to ADD/SUB, so the trap is just its copy.
    assign rsp_err = ovf_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_wide_sequencer
//   Drives alu_wide_sequencer (W=32, WORDS=2) together with a behavioural
//   32-bit ALU, and compares every ALU word transfer and every response
//   against a reference computed on the whole 64-bit operands.
// ---------------------------------------------------------------------------
module tb_alu_wide_sequencer;

    localparam int W     = 32;
    localparam int WORDS = 2;
    localparam int WIDE  = W * WORDS;

    typedef struct {
        logic [WIDE-1:0] a;
        logic [WIDE-1:0] b;
        logic [3:0]      sel;
        logic            cin;
    } req_t;

    typedef struct {
        logic [WIDE-1:0] y;
        logic            cout;
        logic            neg;
        logic            zero;
        logic            ovf;
        logic            err;
        logic [WIDE-1:0] carries;  // carry into each bit position
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [WIDE-1:0] req_a = '0;
    logic [WIDE-1:0] req_b = '0;
    logic [3:0]      req_sel = '0;
    logic            req_cin = 1'b0;
    logic [W-1:0]    alu_a, alu_b;
    logic [3:0]      alu_sel;
    logic            alu_cin;
    logic [W-1:0]    alu_y;
    logic            alu_cout, alu_neg, alu_zero, alu_ovf;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [WIDE-1:0] rsp_y;
    logic            rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_wide_sequencer #(.W(W), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .req_cin   (req_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_cin   (alu_cin),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout),
        .alu_neg   (alu_neg),
        .alu_zero  (alu_zero),
        .alu_ovf   (alu_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_cout  (rsp_cout),
        .rsp_neg   (rsp_neg),
        .rsp_zero  (rsp_zero),
        .rsp_ovf   (rsp_ovf),
        .rsp_err   (rsp_err)
    );

    // Behavioural 32-bit ALU seen by the sequencer. SUB is a + ~b + cin.
    always_comb begin
        logic [W:0]   s;
        logic [W-1:0] be;
        alu_y    = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        s        = '0;
        be       = (alu_sel == 4'b0111) ? ~alu_b : alu_b;
        case (alu_sel)
            4'b0000: alu_y = alu_a & alu_b;
            4'b0001: alu_y = alu_a | alu_b;
            4'b0010: alu_y = ~alu_a;
            4'b0011: alu_y = ~(alu_a | alu_b);
            4'b0100: alu_y = alu_a ^ alu_b;
            4'b0101: alu_y = ~(alu_a & alu_b);
            4'b0110, 4'b0111: begin
                s        = {1'b0, alu_a} + {1'b0, be} + {{W{1'b0}}, alu_cin};
                alu_y    = s[W-1:0];
                alu_cout = s[W];
                alu_ovf  = (alu_a[W-1] == be[W-1]) && (alu_y[W-1] != alu_a[W-1]);
            end
            default: alu_y = alu_a;
        endcase
        alu_neg  = alu_y[W-1];
        alu_zero = (alu_y == '0);
    end

    // Reference: the whole operation done once on 64-bit values.
    function automatic rsp_t ref_op(input req_t r);
        rsp_t            e;
        logic [WIDE:0]   s;
        logic [WIDE-1:0] be;
        logic            arith;
        arith     = (r.sel == 4'b0110) || (r.sel == 4'b0111);
        be        = (r.sel == 4'b0111) ? ~r.b : r.b;
        s         = {1'b0, r.a} + {1'b0, be} + {{WIDE{1'b0}}, r.cin};
        e.carries = s[WIDE-1:0] ^ r.a ^ be;
        e.cout    = 1'b0;
        e.ovf     = 1'b0;
        case (r.sel)
            4'b0000: e.y = r.a & r.b;
            4'b0001: e.y = r.a | r.b;
            4'b0010: e.y = ~r.a;
            4'b0011: e.y = ~(r.a | r.b);
            4'b0100: e.y = r.a ^ r.b;
            4'b0101: e.y = ~(r.a & r.b);
            default: e.y = r.a;
        endcase
        if (arith) begin
            e.y    = s[WIDE-1:0];
            e.cout = s[WIDE];
            e.ovf  = (r.a[WIDE-1] == be[WIDE-1]) && (e.y[WIDE-1] != r.a[WIDE-1]);
        end
        e.neg  = e.y[WIDE-1];
        e.zero = (e.y == '0);
`ifdef ALU_SEQ_OVF_TRAP_EN
        e.err = e.ovf;
`else
        e.err = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [WIDE-1:0] obs,
                         input logic [WIDE-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1'b1);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_alu_a"}, alu_a, '0);
        check({tag, "_alu_b"}, alu_b, '0);
        check({tag, "_alu_sel"}, alu_sel, '0);
        check({tag, "_alu_cin"}, alu_cin, 1'b0);
    endtask

    // Present r, wait (bounded) for acceptance, check each word and the
    // response, hold rsp_ready low for 'hold' cycles, then handshake.
    // If pend_en, request 'nxt' is presented from the first EXEC cycle on.
    task automatic issue(input string tag, input req_t r, input int hold,
                         input logic pend_en, input req_t nxt);
        rsp_t e;
        int   waited;
        logic exp_cin;
        e         = ref_op(r);
        req_valid = 1'b1;
        req_a     = r.a;
        req_b     = r.b;
        req_sel   = r.sel;
        req_cin   = r.cin;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept"}, req_ready, 1'b1);
        @(negedge clk);
        req_valid = pend_en;
        req_a     = pend_en ? nxt.a   : {$urandom, $urandom};
        req_b     = pend_en ? nxt.b   : {$urandom, $urandom};
        req_sel   = pend_en ? nxt.sel : 4'($urandom);
        req_cin   = pend_en ? nxt.cin : 1'($urandom);
        for (int k = 0; k < WORDS; k++) begin
            exp_cin = (k == 0) ? r.cin
                    : (((r.sel == 4'b0110) || (r.sel == 4'b0111)) && e.carries[k*W]);
            check({tag, "_exec_req_ready"}, req_ready, 1'b0);
            check({tag, "_exec_rsp_valid"}, rsp_valid, 1'b0);
            check({tag, "_alu_a"}, alu_a, r.a[k*W +: W]);
            check({tag, "_alu_b"}, alu_b, r.b[k*W +: W]);
            check({tag, "_alu_sel"}, alu_sel, r.sel);
            check({tag, "_alu_cin"}, alu_cin, exp_cin);
            @(negedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
            check({tag, "_rsp_req_ready"}, req_ready, 1'b0);
            check({tag, "_rsp_y"}, rsp_y, e.y);
            check({tag, "_rsp_flags"}, {rsp_cout, rsp_neg, rsp_zero, rsp_ovf},
                  {e.cout, e.neg, e.zero, e.ovf});
            check({tag, "_rsp_err"}, rsp_err, e.err);
            check({tag, "_rsp_alu_idle"}, {alu_a, alu_b, alu_sel, alu_cin}, '0);
            if (h < hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_post_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_post_req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        req_t r, r2, none;
        int   guard;

        none = '{a: '0, b: '0, sel: 4'b0000, cin: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_rsp_y", rsp_y, '0);
        check("reset_rsp_flags", {rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle");

        // 1: carry ripples from word 0 into word 1
        r = '{a: 64'h00000000_FFFFFFFF, b: 64'h1, sel: 4'b0110, cin: 1'b0};
        issue("add_carry", r, 0, 1'b0, none);

        // 2: signed overflow into the top bit
        r = '{a: 64'h7FFFFFFF_FFFFFFFF, b: 64'h1, sel: 4'b0110, cin: 1'b0};
        issue("add_ovf", r, 0, 1'b0, none);

        // 3: XOR of equal operands, carry-in must not chain
        r = '{a: 64'hDEADBEEF_12345678, b: 64'hDEADBEEF_12345678, sel: 4'b0100, cin: 1'b0};
        issue("xor_zero", r, 0, 1'b0, none);

        // 4: back-pressure with a second request waiting
        r  = '{a: 64'h12345678_9ABCDEF0, b: 64'h0FEDCBA9_87654321, sel: 4'b0001, cin: 1'b1};
        r2 = '{a: 64'hFFFFFFFF_FFFFFFFF, b: 64'h0, sel: 4'b0110, cin: 1'b1};
        issue("backpressure", r, 5, 1'b1, r2);
        check("pending_ready_now", req_ready, 1'b1);
        issue("pending", r2, 0, 1'b0, none);

        // 5: reset while executing word 1
        req_valid = 1'b1;
        req_a     = 64'h00000000_FFFFFFFF;
        req_b     = 64'h1;
        req_sel   = 4'b0110;
        req_cin   = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_alu_a", alu_a, 32'h0);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        check("rst_mid_rsp_y", rsp_y, '0);
        check("rst_mid_flags", {rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        guard = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) guard++;
        end
        check("rst_no_rsp", guard, 0);
        check("rst_release_ready", req_ready, 1'b1);

        // 6: SUB with carry-in 1 means plain 0 - 1
        r = '{a: 64'h0, b: 64'h1, sel: 4'b0111, cin: 1'b1};
        issue("sub_borrow", r, 0, 1'b0, none);

        // NOT with an ignored B, and an unlisted op code
        r = '{a: 64'h0F0F0F0F_00000000, b: 64'hFFFFFFFF_FFFFFFFF, sel: 4'b0010, cin: 1'b1};
        issue("not", r, 1, 1'b0, none);
        r = '{a: 64'h80000000_FFFFFFFF, b: 64'h80000000_00000001, sel: 4'b1010, cin: 1'b1};
        issue("unlisted", r, 0, 1'b0, none);

        // Randomized operations, mixing back-to-back and back-pressure
        r = '{a: {$urandom, $urandom}, b: {$urandom, $urandom},
              sel: 4'($urandom_range(0, 9)), cin: 1'($urandom)};
        for (int n = 0; n < 40; n++) begin
            logic pend;
            pend = 1'($urandom);
            r2   = '{a: {$urandom, $urandom}, b: {$urandom, $urandom},
                     sel: 4'($urandom_range(0, 9)), cin: 1'($urandom)};
            if ($urandom_range(0, 3) == 0) r2.b = ~r2.a;
            if ($urandom_range(0, 3) == 0) r2.a = {1'b0, {(WIDE-1){1'b1}}};
            issue("rand", r, $urandom_range(0, 3), pend, r2);
            r = r2;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
